dc_rd_data_align: RTL
=====================

Name: dc_rd_data_align

Overview:
Load-side counterpart of the dcache store data/mask generator. It accepts a load (line address, byte offset, size) and issues one or two dcache line reads. For a line-crossing load it issues a second read to the next line. It extracts and merges the addressed bytes from the 16-byte line(s) and returns a right-justified 64-bit load result to the memory stage.

Parameters:
ADDR_W, 32, byte address width; line address is ADDR_W-4 bits (16-byte lines)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ld_req  in  1  load request; accepted when ld_req & ld_rdy
ld_rdy  out  1  block idle, can accept a load
ld_line_addr  in  ADDR_W-4  line address of first byte
ld_offset  in  4  byte offset within line
ld_size  in  2  00=1B, 01=2B, 10=4B, 11=8B
ld_signed  in  1  sign-extend request (used only with DC_RD_SIGN_EXT_EN)
dc_rd_req  out  1  dcache read request, held until acked
dc_rd_line_addr  out  ADDR_W-4  line address for current access
dc_rd_ack  in  1  dc_rd_data valid this cycle (hit or fill)
dc_rd_data  in  128  line data, byte 0 in bits [7:0]
ld_data  out  64  aligned load result
ld_valid  out  1  one-cycle pulse, ld_data valid
ld_split  out  1  current/last load required two accesses (debug/perf)

Behaviour:
- Reset values: ld_rdy=1 after the reset cycle, dc_rd_req=0, dc_rd_line_addr=0, ld_data=0, ld_valid=0, ld_split=0, state=IDLE, holding register=0.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: ld_rdy=1.
  - On ld_req: latch addr, offset, size, signed.
  - Compute end = offset + nbytes - 1 (5-bit).
  - Set split = end[4] and ld_split = split.
  - Go to ACC1.
  - ld_req is ignored in every state other than IDLE.
- ACC1: dc_rd_req=1, dc_rd_line_addr=latched addr.
  - On dc_rd_ack: capture dc_rd_data rotated right by offset bytes into the holding register low bytes.
  - Go to ACC2 if split, else DONE.
- ACC2: dc_rd_req=1, dc_rd_line_addr=addr+1, modulo 2^(ADDR_W-4); all-ones wraps to 0.
  - On dc_rd_ack: fill bytes [16-offset .. nbytes-1] of the result from line bytes [0 .. end-16].
  - Go to DONE.
- DONE: ld_valid=1 for exactly one cycle; ld_data=merged bytes, upper bytes beyond nbytes zeroed; next state IDLE.
  - ld_data holds its value until the next DONE.
- Latency: non-split load accepted at cycle 0 with ack in the first ACC1 cycle gives ld_valid at cycle 2; a split load with immediate acks gives ld_valid at cycle 3. Each cycle of ack delay adds one cycle.
- dc_rd_req and dc_rd_line_addr are stable from assertion until ack. The request deasserts the cycle after ack, except ACC1->ACC2, where it stays high and the address increments.
- dc_rd_ack outside ACC1/ACC2 is ignored.
- Boundary cases:
  - offset=15, size=1B: non-split.
  - offset=9, size=8B: split (end=16), one byte from line+1.
  - offset=0, size=8B: non-split.
- rst asserted in any state: next cycle IDLE, request dropped, no ld_valid, and the partial holding register is cleared.

Optional Feature:
DC_RD_SIGN_EXT_EN
- Defined: when the latched ld_signed=1 and size<8B, ld_data bits above nbytes*8 replicate bit nbytes*8-1.
- Undefined: ld_signed is ignored and the result is always zero-extended.

Decomposition:
- Shared package dc_pkg:
  - DC_LINE_BYTES=16, DC_LINE_W=128.
  - Size encodings DC_SZ_1B/2B/4B/8B.
  - State encoding typedef dc_rd_state_t.
  - Function size-to-nbytes.
- One sub-module byte_rotate_right (NUM_BYTES parameter, 4-bit amt), the mirror of the existing left-rotator, used for line extraction in ACC1 and ACC2.

Test Plan:
- Aligned: line 0x100, off 0, 8B; data bytes 0x00..0x0F; immediate ack -> one request, ld_valid at cycle 2, ld_data=0x0706050403020100, ld_split=0.
- Sub-word: off 0xE, 2B, bytes 0x00..0x0F -> ld_data=0x0000_0000_0000_0F0E; DC_RD_SIGN_EXT_EN, signed, 1B at off 0x3 with byte 0x83 -> 0xFFFF_FFFF_FFFF_FF83.
- Split: line 0x100 off 0xC 8B; line 0x100 bytes 0xA0..0xAF, 0x101 bytes 0xB0..0xBF -> requests to 0x100 then 0x101, ld_data=0xB3B2B1B0AFAEADAC, ld_split=1, ld_valid at cycle 3.
- Stalled ack: ack delayed 5 cycles in ACC1 -> dc_rd_req and address held stable, ld_valid at cycle 7; a ld_req during the stall is not accepted (ld_rdy=0).
- Wrap: line all-ones, off 0xF, 2B -> second request to line 0.
- Reset mid-split: rst during ACC2 -> next cycle dc_rd_req=0, ld_rdy=1, no ld_valid; the following aligned load returns correct data with no stale bytes.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared dcache definitions: line geometry, load-size encodings, the
// read-align FSM state type and the size-to-byte-count decode.
package dc_pkg;

  localparam int DC_LINE_BYTES = 16;
  localparam int DC_LINE_W     = 128;

  localparam logic [1:0] DC_SZ_1B = 2'b00;
  localparam logic [1:0] DC_SZ_2B = 2'b01;
  localparam logic [1:0] DC_SZ_4B = 2'b10;
  localparam logic [1:0] DC_SZ_8B = 2'b11;

  typedef enum logic [1:0] {
    DC_RD_IDLE = 2'd0,
    DC_RD_ACC1 = 2'd1,
    DC_RD_ACC2 = 2'd2,
    DC_RD_DONE = 2'd3
  } dc_rd_state_t;

  // Number of bytes moved by a load of the given size encoding.
  function automatic logic [3:0] dc_size_nbytes(input logic [1:0] size);
    logic [3:0] nb;
    case (size)
      DC_SZ_1B: nb = 4'd1;
      DC_SZ_2B: nb = 4'd2;
      DC_SZ_4B: nb = 4'd4;
      default:  nb = 4'd8;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/byte_rotate_right.sv
// Byte-granular right rotator: output byte i takes input byte (i + amt)
// modulo NUM_BYTES, so the byte at offset amt lands in byte 0.
module byte_rotate_right #(
  parameter int NUM_BYTES = 16
) (
  input  logic [3:0]             amt,
  input  logic [NUM_BYTES*8-1:0] din,
  output logic [NUM_BYTES*8-1:0] dout
);

  // Pure byte-lane permutation selected by the rotate amount.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      dout[i*8 +: 8] = din[((i + int'(amt)) % NUM_BYTES)*8 +: 8];
    end
  end

endmodule

// File: rtl/dc_rd_data_align.sv
// Load data aligner: issues one or two dcache line reads for a load,
// extracts the addressed bytes and returns a right-justified 64-bit result.
// Optional build macro DC_RD_SIGN_EXT_EN enables sign extension of
// sub-doubleword loads when ld_signed is set; otherwise results are
// always zero-extended.
module dc_rd_data_align
  import dc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  output logic              ld_rdy,
  input  logic [ADDR_W-5:0] ld_line_addr,
  input  logic [3:0]        ld_offset,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic              dc_rd_req,
  output logic [ADDR_W-5:0] dc_rd_line_addr,
  input  logic              dc_rd_ack,
  input  logic [127:0]      dc_rd_data,
  output logic [63:0]       ld_data,
  output logic              ld_valid,
  output logic              ld_split
);

  localparam int LA_W = ADDR_W - 4;

  dc_rd_state_t    state;
  logic [LA_W-1:0] addr_q;
  logic [3:0]      off_q;
  logic [1:0]      size_q;
  logic            split_q;
  logic [63:0]     hold_q;

  logic [3:0]           nbytes_q;
  logic [4:0]           end_w;
  logic [DC_LINE_W-1:0] rot_line;
  logic [63:0]          rot64;
  logic [63:0]          merged;
  logic                 sext;

  // Zero- or sign-extend the low nb bytes of d to 64 bits.
  function automatic logic [63:0] fmt_result(input logic [63:0] d,
                                             input logic [3:0]  nb,
                                             input logic        sgn);
    logic [63:0] r;
    logic        fill;
    fill = sgn & d[int'(nb)*8-1];
    r    = d;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(nb)) r[i*8 +: 8] = {8{fill}};
    end
    return r;
  endfunction

  assign nbytes_q = dc_size_nbytes(size_q);
  assign end_w    = {1'b0, ld_offset} + {1'b0, dc_size_nbytes(ld_size)} - 5'd1;

  // Rotating both lines by the same offset right-justifies the first line
  // and puts the second line's leading bytes exactly at result byte 16-off.
  byte_rotate_right #(
    .NUM_BYTES(DC_LINE_BYTES)
  ) u_rot (
    .amt  (off_q),
    .din  (dc_rd_data),
    .dout (rot_line)
  );

  assign rot64 = rot_line[63:0];

`ifdef DC_RD_SIGN_EXT_EN
  logic signed_q;

  // Signed flag captured with the rest of the load descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_q <= 1'b0;
    end else if (state == DC_RD_IDLE && ld_req) begin
      signed_q <= ld_signed;
    end
  end

  assign sext = signed_q;

  logic unused_bits;
  assign unused_bits = ^rot_line[127:64];
`else
  assign sext = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{ld_signed, rot_line[127:64]};
`endif

  // Second-access merge: bytes that wrapped past the first line come from
  // the freshly rotated second line, the rest from the holding register.
  always_comb begin
    merged = rot64;
    if (state == DC_RD_ACC2) begin
      for (int i = 0; i < 8; i++) begin
        if ((int'(off_q) + i) < DC_LINE_BYTES) merged[i*8 +: 8] = hold_q[i*8 +: 8];
      end
    end
  end

  // Access sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= DC_RD_IDLE;
      ld_rdy          <= 1'b1;
      dc_rd_req       <= 1'b0;
      dc_rd_line_addr <= '0;
      ld_data         <= '0;
      ld_valid        <= 1'b0;
      ld_split        <= 1'b0;
      hold_q          <= '0;
      addr_q          <= '0;
      off_q           <= '0;
      size_q          <= DC_SZ_1B;
      split_q         <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      case (state)
        DC_RD_IDLE: begin
          if (ld_req) begin
            addr_q          <= ld_line_addr;
            off_q           <= ld_offset;
            size_q          <= ld_size;
            split_q         <= end_w[4];
            ld_split        <= end_w[4];
            ld_rdy          <= 1'b0;
            dc_rd_req       <= 1'b1;
            dc_rd_line_addr <= ld_line_addr;
            state           <= DC_RD_ACC1;
          end
        end
        DC_RD_ACC1: begin
          if (dc_rd_ack) begin
            hold_q <= rot64;
            if (split_q) begin
              dc_rd_line_addr <= addr_q + LA_W'(1);
              state           <= DC_RD_ACC2;
            end else begin
              dc_rd_req <= 1'b0;
              ld_data   <= fmt_result(merged, nbytes_q, sext);
              ld_valid  <= 1'b1;
              state     <= DC_RD_DONE;
            end
          end
        end
        DC_RD_ACC2: begin
          if (dc_rd_ack) begin
            hold_q    <= merged;
            dc_rd_req <= 1'b0;
            ld_data   <= fmt_result(merged, nbytes_q, sext);
            ld_valid  <= 1'b1;
            state     <= DC_RD_DONE;
          end
        end
        default: begin
          ld_rdy <= 1'b1;
          state  <= DC_RD_IDLE;
        end
      endcase
    end
  end

endmodule
